// File: rtl/bcd_seq_ctrl.sv
// Two-requester binary-to-BCD converter: an arbiter feeds a sequential double-dabble engine.
// Define BCD_SEQ_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module bcd_seq_ctrl #(
  parameter int unsigned BIN_W = 8,
  parameter int unsigned DIG   = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  input  logic [BIN_W-1:0]   i_req0_bin,
  output logic               o_req0_ready,
  input  logic               i_req1_valid,
  input  logic [BIN_W-1:0]   i_req1_bin,
  output logic               o_req1_ready,
  output logic               o_rsp_valid,
  output logic [4*DIG-1:0]   o_rsp_bcd,
  output logic               o_rsp_id,
  input  logic               i_rsp_ready,
  output logic               o_busy
);

  localparam int unsigned BCD_W = 4 * DIG;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned SH_W  = BCD_W + BIN_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;

  logic             idle;
  logic             grant0, grant1;
  logic [BCD_W-1:0] bcd_adj;
  logic [SH_W-1:0]  shifted;

  assign idle = (state_q == ST_IDLE);

`ifdef BCD_SEQ_RR_EN
  // last_q remembers the most recent grant; on a tie the other requester wins
  logic last_q, last_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (idle) begin
      if (i_req0_valid && i_req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = i_req0_valid;
        grant1 = i_req1_valid;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant0 || grant1) last_d = grant1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  always_comb begin
    grant0 = idle && i_req0_valid;
    grant1 = idle && !i_req0_valid && i_req1_valid;
  end
`endif

  // Readies are masked by reset so every output is low while reset is held
  assign o_req0_ready = i_rst_n && grant0;
  assign o_req1_ready = i_rst_n && grant1;

  // Double-dabble step: correct digits >= 5, then shift {bcd, bin} left by one
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIG); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          bin_d   = grant1 ? i_req1_bin : i_req0_bin;
          id_d    = grant1;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = shifted[SH_W-1:BIN_W];
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  // Result fields are exposed only while DONE
  assign o_rsp_valid = (state_q == ST_DONE);
  assign o_busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign o_rsp_bcd   = o_rsp_valid ? bcd_q : '0;
  assign o_rsp_id    = o_rsp_valid && id_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: a transaction-level model predicts grants and
// results (decimal arithmetic); a separate monitor checks each presented response.
module tb_bcd_seq_ctrl;

  localparam int unsigned BIN_W = 8;
  localparam int unsigned DIG   = 3;
  localparam int unsigned BW    = 4 * DIG;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             v0, v1, rsp_rdy;
  logic [BIN_W-1:0] b0, b1;
  logic             o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id, o_busy;
  logic [BW-1:0]    o_rsp_bcd;

  bcd_seq_ctrl #(.BIN_W(BIN_W), .DIG(DIG)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0_valid (v0),
    .i_req0_bin   (b0),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (v1),
    .i_req1_bin   (b1),
    .o_req1_ready (o_req1_ready),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_bcd    (o_rsp_bcd),
    .o_rsp_id     (o_rsp_id),
    .i_rsp_ready  (rsp_rdy),
    .o_busy       (o_busy)
  );

  typedef struct {
    logic [BW-1:0] bcd;
    logic          id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Model state: 0 idle, 1 converting, 2 holding a result
  int   m_st = 0;
  int   rem  = 0;
  logic last = 1'b1;

  function automatic logic [BW-1:0] to_bcd(input int unsigned val);
    logic [BW-1:0] r;
    int unsigned   v;
    r = '0;
    v = val;
    for (int d = 0; d < int'(DIG); d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: predicts arbitration, latency and handshakes cycle by cycle
  always @(negedge clk) begin : model_p
    logic g0, g1;
    if (!rst_n) begin
      m_st = 0;
      rem  = 0;
      last = 1'b1;
      q.delete();
      chk("reset_outputs", 32'({o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_bcd, o_rsp_id, o_busy}), 32'd0);
    end else begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (m_st == 0) begin
`ifdef BCD_SEQ_RR_EN
        if (v0 && v1) begin
          if (last) g0 = 1'b1;
          else      g1 = 1'b1;
        end else begin
          g0 = v0;
          g1 = v1;
        end
`else
        g0 = v0;
        g1 = !v0 && v1;
`endif
      end
      chk("req0_ready", 32'(o_req0_ready), 32'(g0));
      chk("req1_ready", 32'(o_req1_ready), 32'(g1));
      chk("busy",       32'(o_busy),       32'(m_st != 0));
      chk("rsp_valid",  32'(o_rsp_valid),  32'(m_st == 2));
      case (m_st)
        0: if (g0 || g1) begin
          q.push_back('{bcd: to_bcd(32'(g1 ? b1 : b0)), id: g1});
          last = g1;
          rem  = BIN_W;
          m_st = 1;
        end
        1: begin
          rem--;
          if (rem == 0) m_st = 2;
        end
        default: if (rsp_rdy) m_st = 0;
      endcase
    end
  end

  // Monitor: compares each presented response against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(o_rsp_valid), 32'd0);
        end else begin
          chk("rsp_bcd", 32'(o_rsp_bcd), 32'(q[0].bcd));
          chk("rsp_id",  32'(o_rsp_id),  32'(q[0].id));
          if (rsp_rdy) void'(q.pop_front());
        end
      end else begin
        chk("rsp_bcd_idle", 32'(o_rsp_bcd), 32'd0);
        chk("rsp_id_idle",  32'(o_rsp_id),  32'd0);
      end
    end
  end

  task automatic send(input int id, input logic [BIN_W-1:0] val);
    bit ok;
    ok = 1'b0;
    if (id == 0) begin v0 = 1'b1; b0 = val; end
    else         begin v1 = 1'b1; b1 = val; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if ((id == 0 && o_req0_ready) || (id == 1 && o_req1_ready)) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    // Scramble the operand after acceptance; the result must not change
    if (id == 0) begin v0 = 1'b0; b0 = BIN_W'($urandom); end
    else         begin v1 = 1'b0; b1 = BIN_W'($urandom); end
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (m_st == 0 && q.size() == 0) done = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit a0, a1, seen;
    v0 = 1'b0; v1 = 1'b0; b0 = '0; b1 = '0; rsp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_rdy = 1'b1;

    // All-ones operand, then zero and digit-boundary operands from requester 1
    send(0, 8'd255);
    wait_idle();
    send(1, 8'd0);
    send(1, 8'd9);
    send(1, 8'd10);
    wait_idle();

    // Both requesters held valid together
    v0 = 1'b1; b0 = 8'd37; v1 = 1'b1; b1 = 8'd199;
    repeat (60) @(posedge clk);
    #1 v0 = 1'b0;
    repeat (30) @(posedge clk);
    #1 v1 = 1'b0;
    wait_idle();

    // Consumer stalls for 5 cycles in DONE
    rsp_rdy = 1'b0;
    send(0, 8'd123);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = o_rsp_valid;
    end
    chk("stall_rsp_seen", 32'(seen), 32'd1);
    repeat (5) @(posedge clk);
    #1 rsp_rdy = 1'b1;
    wait_idle();

    // Reset in the 4th conversion cycle, then a clean conversion
    send(1, 8'd200);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_immediate", 32'({o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_bcd, o_rsp_id, o_busy}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 8'd77);
    wait_idle();

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      a0 = v0 && o_req0_ready;
      a1 = v1 && o_req1_ready;
      @(posedge clk);
      #1;
      if (a0) begin v0 = 1'b0; b0 = BIN_W'($urandom); end
      else if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1'b1;
        b0 = ($urandom_range(0, 7) == 0) ? '1 : BIN_W'($urandom);
      end
      if (a1) begin v1 = 1'b0; b1 = BIN_W'($urandom); end
      else if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1'b1;
        b1 = ($urandom_range(0, 7) == 0) ? '0 : BIN_W'($urandom);
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
    end
    v0 = 1'b0;
    v1 = 1'b0;
    rsp_rdy = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 SHALL have parameter BIN_W, default 8: binary operand width.
REQ-002 SHALL have parameter DIG, default 3: BCD output digits; legal only if 10^DIG > 2^BIN_W - 1.
REQ-003 SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_req0_valid, input, 1: requester 0 has an operand.
REQ-006 SHALL have port i_req0_bin, input, BIN_W: requester 0 operand.
REQ-007 SHALL have port o_req0_ready, output, 1: requester 0 operand accepted this cycle.
REQ-008 SHALL have port i_req1_valid, input, 1: requester 1 has an operand.
REQ-009 SHALL have port i_req1_bin, input, BIN_W: requester 1 operand.
REQ-010 SHALL have port o_req1_ready, output, 1: requester 1 operand accepted this cycle.
REQ-011 SHALL have port o_rsp_valid, output, 1: result available.
REQ-012 SHALL have port o_rsp_bcd, output, 4*DIG: packed BCD, most significant digit in the top nibble.
REQ-013 SHALL have port o_rsp_id, output, 1: index of the requester that owns the result.
REQ-014 SHALL have port i_rsp_ready, input, 1: consumer takes the result.
REQ-015 SHALL have port o_busy, output, 1: high in the SHIFT and DONE states.

Function
REQ-016 SHALL implement the FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-017 In IDLE, the arbiter SHALL assert combinationally at most one o_reqN_ready, and only to a requester whose valid is high; no ready SHALL be asserted in SHIFT or DONE.
REQ-018 On the acceptance edge (valid & ready), the block SHALL capture the operand and the requester id, clear the BCD field to 0, load a shift counter with BIN_W, and enter SHIFT.
REQ-019 In each SHIFT cycle, the block SHALL first add 3 to every BCD digit that is >= 5, then shift the {bcd, bin} register left by one bit, then decrement the counter.
REQ-020 After exactly BIN_W SHIFT cycles, the block SHALL enter DONE; o_rsp_valid SHALL rise BIN_W cycles after the acceptance edge.
REQ-021 In DONE, o_rsp_valid, o_rsp_bcd and o_rsp_id SHALL hold stable until i_rsp_ready is high; on that edge the block SHALL return to IDLE.
REQ-022 The next acceptance SHALL occur no earlier than the edge after the response handshake; no request is accepted while in DONE.
REQ-023 o_rsp_bcd and o_rsp_id SHALL read 0 whenever the state is not DONE.
REQ-024 Operand changes on a requester input after its acceptance SHALL NOT affect the result in progress.
REQ-025 An operand of 0 SHALL yield an all-zero BCD result; the all-ones operand SHALL convert correctly, with no overflow possible when REQ-002 holds.

Reset
REQ-026 Assertion of i_rst_n low SHALL immediately force IDLE, a zero datapath, a zero counter, and every output to 0; the round-robin pointer SHALL reset to "last = 1".
REQ-027 A reset during SHIFT or DONE SHALL discard the operation in progress with no response.
REQ-028 After release, the block SHALL accept requests from the first following rising edge.

Configuration
REQ-029 Macro BCD_SEQ_RR_EN SHALL select the arbitration policy.
REQ-030 With BCD_SEQ_RR_EN defined, arbitration SHALL be round-robin: on simultaneous valids, grant the requester not granted last; the pointer updates on every acceptance.
REQ-031 Without BCD_SEQ_RR_EN, arbitration SHALL be fixed priority (requester 0 wins) and the pointer logic SHALL be absent.

Verification
REQ-032 Requester 0 sends 8'd255 with i_rsp_ready=1 -> o_rsp_valid rises 8 cycles after acceptance with o_rsp_bcd=12'h255 and o_rsp_id=0.
REQ-033 Requester 1 sends 8'd0, then 8'd9, then 8'd10 -> results 12'h000, 12'h009 and 12'h010, each with id=1.
REQ-034 Both requesters valid in the same cycle (req0=8'd37, req1=8'd199), BCD_SEQ_RR_EN defined -> first response 12'h037 with id 0, second 12'h199 with id 1; req0 held valid continuously -> grants alternate.
REQ-035 Same stimulus as REQ-034 without BCD_SEQ_RR_EN -> req0 granted every time while it stays valid; req1 is starved until req0 drops.
REQ-036 Hold i_rsp_ready=0 for 5 cycles in DONE -> o_rsp_valid and o_rsp_bcd stay stable and both reqN_ready stay 0; the response completes on the first cycle with i_rsp_ready=1.
REQ-037 Pulse i_rst_n low in the 4th SHIFT cycle -> all outputs are 0 immediately, no response is produced, and a new request after release converts correctly.
